// File: rtl/serial_pattern_tx.sv
// Repeating serial pattern transmitter: bursts of PATTERN frames separated by GAP idle cycles.
// Optional feature: define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit to each frame.
module serial_pattern_tx #(
    parameter int unsigned      PAT_W   = 6,
    parameter logic [PAT_W-1:0] PATTERN = 6'b101111,
    parameter int unsigned      GAP     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] count,
    input  logic       stop,
    output logic       x,
    output logic       valid,
    output logic       busy,
    output logic       done
);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StSend, StPar, StGap, StDone} state_e;
    localparam logic Parity = ^PATTERN;
`else
    typedef enum logic [2:0] {StIdle, StSend, StGap, StDone} state_e;
`endif

    localparam logic [3:0] LastBit = 4'(PAT_W - 1);
    localparam logic [3:0] LastGap = (GAP != 0) ? 4'(GAP - 1) : 4'd0;

    state_e           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       rep_q, rep_d;
    logic [3:0]       count_q, count_d;
    logic             stop_q, stop_d;
    logic             stop_seen;
    logic             last_rep;
    state_e           frame_next;
    logic [PAT_W-1:0] pat_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= 4'd0;
            rep_q     <= 4'd0;
            count_q   <= 4'd0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rep_q     <= rep_d;
            count_q   <= count_d;
            stop_q    <= stop_d;
        end
    end

    // A stop arriving on the deciding edge counts as well as an earlier sticky one.
    assign stop_seen = stop_q | stop;
    assign last_rep  = (count_q != 4'd0) && ((rep_q + 4'd1) == count_q);

    always_comb begin
        frame_next = StSend;
        if (stop_seen || last_rep) begin
            frame_next = StDone;
        end else if (GAP != 0) begin
            frame_next = StGap;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rep_d     = rep_q;
        count_d   = count_q;
        stop_d    = stop_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StSend;
                    bit_cnt_d = 4'd0;
                    rep_d     = 4'd0;
                    count_d   = count;
                    stop_d    = stop;
                end
            end
            StSend: begin
                stop_d = stop_seen;
                if (bit_cnt_q == LastBit) begin
                    bit_cnt_d = 4'd0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    state_d = StPar;
`else
                    state_d = frame_next;
                    rep_d   = rep_q + 4'd1;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            StPar: begin
                stop_d  = stop_seen;
                state_d = frame_next;
                rep_d   = rep_q + 4'd1;
            end
`endif
            StGap: begin
                stop_d = stop_seen;
                if (stop_seen) begin
                    state_d   = StDone;
                    bit_cnt_d = 4'd0;
                end else if (bit_cnt_q == LastGap) begin
                    state_d   = StSend;
                    bit_cnt_d = 4'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                stop_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    // MSB-first: shift the current bit up into the top position.
    assign pat_shift = PATTERN << bit_cnt_q;

    always_comb begin
        x     = 1'b0;
        valid = 1'b0;
        busy  = (state_q != StIdle);
        done  = (state_q == StDone);
        if (state_q == StSend) begin
            x     = pat_shift[PAT_W-1];
            valid = 1'b1;
        end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        if (state_q == StPar) begin
            x     = Parity;
            valid = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed self-checking bench for serial_pattern_tx with PATTERN=101111, GAP=2.
module tb_serial_pattern_tx;

    localparam int unsigned PAT_W = 6;
    localparam int unsigned GAP   = 2;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int FL = 7;
`else
    localparam int FL = 6;
`endif
    localparam int P = FL + GAP;
    localparam logic [5:0] PAT = 6'b101111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic       stop = 1'b0;
    logic       x, valid, busy, done;

    int checks = 0;
    int errors = 0;

    logic tr_x [64];
    logic tr_v [64];
    logic tr_b [64];
    logic tr_d [64];

    serial_pattern_tx #(
        .PAT_W  (PAT_W),
        .PATTERN(6'b101111),
        .GAP    (GAP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .count(count),
        .stop (stop),
        .x    (x),
        .valid(valid),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            tr_x[i] = x;
            tr_v[i] = valid;
            tr_b[i] = busy;
            tr_d[i] = done;
            tick();
        end
    endtask

    // Expected behaviour of an n-frame burst, c = cycles since the first bit.
    function automatic logic exp_bit(input int k);
        if (k < 6) return PAT[5-k];
        return 1'b1;
    endfunction

    function automatic logic m_valid(input int c, input int n);
        return (c >= 0) && (c < (n - 1) * P + FL) && ((c % P) < FL);
    endfunction

    function automatic logic m_x(input int c, input int n);
        return m_valid(c, n) ? exp_bit(c % P) : 1'b0;
    endfunction

    function automatic logic m_done(input int c, input int n);
        return c == (n - 1) * P + FL;
    endfunction

    function automatic logic m_busy(input int c, input int n);
        return (c >= 0) && (c <= (n - 1) * P + FL);
    endfunction

    task automatic pulse_start(input logic [3:0] cnt, input logic stp);
        count = cnt;
        stop  = stp;
        start = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        checks++;
        if ({x, valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: x/valid/busy/done=%b expected 0000",
                     {x, valid, busy, done});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_single();
        pulse_start(4'd1, 1'b0);
        record(FL + 4);
        for (int c = 0; c < FL + 4; c++) begin
            checks++;
            if ({tr_x[c], tr_v[c], tr_b[c], tr_d[c]} !==
                {m_x(c, 1), m_valid(c, 1), m_busy(c, 1), m_done(c, 1)}) begin
                errors++;
                $display("FAIL single c=%0d: x/v/b/d=%b expected %b", c,
                         {tr_x[c], tr_v[c], tr_b[c], tr_d[c]},
                         {m_x(c, 1), m_valid(c, 1), m_busy(c, 1), m_done(c, 1)});
            end
        end
    endtask

    task automatic test_multi();
        int dones;
        dones = 0;
        pulse_start(4'd3, 1'b0);
        record(2 * P + FL + 5);
        for (int c = 0; c < 2 * P + FL + 5; c++) begin
            dones += int'(tr_d[c]);
            checks++;
            if ({tr_x[c], tr_v[c], tr_b[c], tr_d[c]} !==
                {m_x(c, 3), m_valid(c, 3), m_busy(c, 3), m_done(c, 3)}) begin
                errors++;
                $display("FAIL multi c=%0d: x/v/b/d=%b expected %b", c,
                         {tr_x[c], tr_v[c], tr_b[c], tr_d[c]},
                         {m_x(c, 3), m_valid(c, 3), m_busy(c, 3), m_done(c, 3)});
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL multi_done_count: got %0d expected 1", dones);
        end
    endtask

    task automatic test_continuous_stop();
        pulse_start(4'd0, 1'b0);
        for (int i = 0; i < P + 2; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        record(FL + 2);
        for (int r = 0; r < FL + 2; r++) begin
            checks++;
            if ({tr_x[r], tr_v[r], tr_b[r], tr_d[r]} !== {m_x(P + 3 + r, 2),
                m_valid(P + 3 + r, 2), m_busy(P + 3 + r, 2), m_done(P + 3 + r, 2)}) begin
                errors++;
                $display("FAIL cont_stop c=%0d: x/v/b/d=%b expected %b", P + 3 + r,
                         {tr_x[r], tr_v[r], tr_b[r], tr_d[r]}, {m_x(P + 3 + r, 2),
                         m_valid(P + 3 + r, 2), m_busy(P + 3 + r, 2), m_done(P + 3 + r, 2)});
            end
        end
    endtask

    task automatic test_stop_gap();
        pulse_start(4'd0, 1'b0);
        for (int i = 0; i < FL; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if ({valid, busy, done} !== 3'b011) begin
            errors++;
            $display("FAIL stop_gap_done: valid/busy/done=%b expected 011", {valid, busy, done});
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL stop_gap_idle: busy/done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_reset_mid();
        pulse_start(4'd1, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        checks++;
        if ({x, valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: x/valid/busy/done=%b expected 0000", {x, valid, busy, done});
        end
        record(4);
        for (int r = 0; r < 4; r++) begin
            checks++;
            if ({tr_b[r], tr_d[r]} !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid_quiet r=%0d: busy/done=%b expected 00", r,
                         {tr_b[r], tr_d[r]});
            end
        end
        pulse_start(4'd1, 1'b0);
        record(FL + 2);
        for (int c = 0; c < FL + 2; c++) begin
            checks++;
            if ({tr_x[c], tr_v[c], tr_d[c]} !== {m_x(c, 1), m_valid(c, 1), m_done(c, 1)}) begin
                errors++;
                $display("FAIL restart c=%0d: x/v/d=%b expected %b", c,
                         {tr_x[c], tr_v[c], tr_d[c]}, {m_x(c, 1), m_valid(c, 1), m_done(c, 1)});
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        pulse_start(4'd2, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        start = 1'b1;
        count = 4'd5;
        tick();
        start = 1'b0;
        record(P + FL);
        for (int r = 0; r < P + FL; r++) begin
            dones += int'(tr_d[r]);
            checks++;
            if ({tr_x[r], tr_v[r], tr_b[r], tr_d[r]} !== {m_x(4 + r, 2), m_valid(4 + r, 2),
                m_busy(4 + r, 2), m_done(4 + r, 2)}) begin
                errors++;
                $display("FAIL back_to_back c=%0d: x/v/b/d=%b expected %b", 4 + r,
                         {tr_x[r], tr_v[r], tr_b[r], tr_d[r]}, {m_x(4 + r, 2),
                         m_valid(4 + r, 2), m_busy(4 + r, 2), m_done(4 + r, 2)});
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL back_to_back_done_count: got %0d expected 1", dones);
        end
    endtask

    task automatic test_stop_idle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle_ignored: busy=%b expected 0", busy);
        end
        pulse_start(4'd2, 1'b0);
        record(P + FL + 2);
        for (int c = 0; c < P + FL + 2; c++) begin
            checks++;
            if ({tr_v[c], tr_d[c]} !== {m_valid(c, 2), m_done(c, 2)}) begin
                errors++;
                $display("FAIL stop_idle_burst c=%0d: v/d=%b expected %b", c,
                         {tr_v[c], tr_d[c]}, {m_valid(c, 2), m_done(c, 2)});
            end
        end
        pulse_start(4'd0, 1'b1);
        record(FL + 3);
        for (int c = 0; c < FL + 3; c++) begin
            checks++;
            if ({tr_x[c], tr_v[c], tr_b[c], tr_d[c]} !==
                {m_x(c, 1), m_valid(c, 1), m_busy(c, 1), m_done(c, 1)}) begin
                errors++;
                $display("FAIL start_with_stop c=%0d: x/v/b/d=%b expected %b", c,
                         {tr_x[c], tr_v[c], tr_b[c], tr_d[c]},
                         {m_x(c, 1), m_valid(c, 1), m_busy(c, 1), m_done(c, 1)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        tick();
        test_multi();
        tick();
        test_continuous_stop();
        tick();
        test_stop_gap();
        tick();
        test_reset_mid();
        tick();
        test_back_to_back();
        tick();
        test_stop_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 The block SHALL have parameter PAT_W, default 6, meaning pattern length in bits (2..16).
REQ-002 The block SHALL have parameter PATTERN, default 6'b101111, meaning the bit pattern transmitted MSB-first.
REQ-003 The block SHALL have parameter GAP, default 2, meaning idle cycles between repetitions (0..15).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic on posedge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit, which requests a burst and is sampled only in IDLE.
REQ-007 The block SHALL have port count, input, 4 bits, the repetitions per burst latched at start, where 0 means continuous.
REQ-008 The block SHALL have port stop, input, 1 bit, which requests burst termination after the current pattern.
REQ-009 The block SHALL have port x, output, 1 bit, the serial data bit, held 0 when not valid.
REQ-010 The block SHALL have port valid, output, 1 bit, high when x carries a pattern or parity bit.
REQ-011 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking burst completion.

Function
REQ-013 The FSM SHALL have states IDLE, SEND, PAR (only when PARITY_EN is defined), GAP and DONE.
REQ-014 x, valid, busy and done SHALL be decoded from the registered state and the bit counter only (Moore outputs).
REQ-015 In IDLE with start=1 at edge k, the FSM SHALL enter SEND, latch count, and drive PATTERN[PAT_W-1] with valid=1 during cycle k+1.
REQ-016 SEND SHALL emit PATTERN[PAT_W-1] down to PATTERN[0] over PAT_W consecutive cycles with valid=1.
REQ-017 After the last pattern bit (or PAR, when enabled), the FSM SHALL go to DONE if this was the final repetition or stop was seen; otherwise it SHALL go to GAP if GAP>0 and to SEND if GAP=0.
REQ-018 GAP SHALL last exactly GAP cycles with x=0 and valid=0, then return to SEND.
REQ-019 The repetition counter SHALL be 4 bits wide; the final repetition is the one where completed repetitions equal the latched count; with count=0 the counter SHALL not terminate the burst.
REQ-020 Stop SHALL be sticky from assertion until burst end, a stop during SEND SHALL complete the current pattern, and a stop during GAP SHALL go to DONE on the next edge.
REQ-021 DONE SHALL last one cycle with done=1, busy=1 and valid=0, then go to IDLE.
REQ-022 Start asserted while busy=1 SHALL be ignored, and a change of count mid-burst SHALL have no effect.
REQ-023 In IDLE, stop SHALL be ignored; start=1 with stop=1 SHALL start a burst that ends after its first pattern.
REQ-024 For count=N, GAP=G and no parity, the burst SHALL span N*PAT_W+(N-1)*G cycles from first bit to the cycle before done.

Reset
REQ-025 With rst=1 at a posedge, the FSM SHALL enter IDLE and clear the bit counter, repetition counter and sticky stop, giving x=0, valid=0, busy=0 and done=0 the next cycle.
REQ-026 Reset mid-burst SHALL abort transmission with no done pulse, and reset SHALL take priority over start.

Configuration
REQ-027 With macro SERIAL_PATTERN_TX_PARITY_EN defined, each pattern SHALL be followed by one PAR cycle with valid=1 and x equal to the even parity (XOR) of PATTERN, which is 1 for 101111.
REQ-028 Without SERIAL_PATTERN_TX_PARITY_EN, there SHALL be no PAR state and the pattern SHALL be followed directly by GAP, SEND or DONE.

Verification
REQ-029 Defaults, no parity, count=1, start pulsed one cycle: x=1,0,1,1,1,1 with valid=1 for 6 cycles, then done=1 for 1 cycle, then busy=0.
REQ-030 count=3, GAP=2: the bench SHALL see three 101111 frames separated by 2 cycles of valid=0, 22 cycles first bit to last bit, and a single done pulse.
REQ-031 count=0 with stop pulsed during the 2nd frame's 3rd bit: the 2nd frame completes, then done, with no 3rd frame.
REQ-032 rst=1 during the 4th bit of a frame: the next cycle shows busy=0, valid=0, x=0 and no done; a new start then restarts from bit 1.
REQ-033 start re-pulsed mid-burst (count=2): the burst length is unchanged and exactly one done pulse occurs.
REQ-034 With SERIAL_PATTERN_TX_PARITY_EN and count=1: x=1,0,1,1,1,1,1 with valid=1 for 7 cycles, then done.
